// File: rtl/lrhls_top_sdiv_seq_36s_18s.sv
// -----------------------------------------------------------------------------
// lrhls_top_sdiv_seq_36s_18s
//
// Sequential signed divider: a DIVIDEND_WIDTH-bit two's-complement dividend is
// divided by a DIVISOR_WIDTH-bit two's-complement divisor. The quotient is
// truncated toward zero and the remainder takes the sign of the dividend. The
// block inverts the 18s x 18s -> 36 product path of the LRHLS_top datapath, so
// a fit term can be recovered from a product and one known factor.
//
// Algorithm: radix-2 restoring division on operand magnitudes, one quotient
// bit per clock (DIVIDEND_WIDTH cycles), then one sign-fixup cycle. Only one
// division is in flight at a time.
//
// Ports:
//   ap_clk       in   clock, rising edge
//   ap_rst_n     in   asynchronous active-low reset
//   din_valid    in   operands valid
//   din_ready    out  operands can be accepted (IDLE only)
//   dividend     in   signed dividend
//   divisor      in   signed divisor
//   dout_valid   out  result valid (DONE only)
//   dout_ready   in   downstream accepts result
//   quotient     out  signed quotient
//   remainder    out  signed remainder
//   div_by_zero  out  divisor was zero for this result
//   overflow     out  most-negative dividend divided by -1
//   busy         out  high in CALC, FIX and DONE
//
// All outputs come straight from flops; there is no input-to-output path.
// -----------------------------------------------------------------------------
module lrhls_top_sdiv_seq_36s_18s #(
   parameter int unsigned DIVIDEND_WIDTH = 36,
   parameter int unsigned DIVISOR_WIDTH  = 18
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      din_valid,
   output logic                      din_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [DIVIDEND_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero,
   output logic                      overflow,
   output logic                      busy
);

   localparam int unsigned DW   = DIVIDEND_WIDTH;
   localparam int unsigned VW   = DIVISOR_WIDTH;
   localparam int unsigned CntW = $clog2(DW);

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } state_e;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_e            r_state;
   logic [CntW-1:0]   r_cnt;
   // Dividend magnitude shifts out at the top while quotient bits shift in at
   // the bottom. An unsigned DW-bit register already holds 2^(DW-1).
   logic [DW-1:0]     r_q;
   // Partial remainder is one bit wider than the divisor so that a doubled
   // remainder below |divisor| never loses its top bit.
   logic [VW:0]       r_rem;
   logic [VW-1:0]     r_dvs_mag;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_dvs_zero;
   logic              r_ovf;
   logic [VW-1:0]     r_dvd_lo;

   // Registered outputs
   logic              r_din_ready;
   logic              r_dout_valid;
   logic              r_busy;
   logic [DW-1:0]     r_quotient;
   logic [VW-1:0]     r_remainder;
   logic              r_div_by_zero;
   logic              r_overflow;

   // ---------------------------------------------------------------------------
   // Operand conditioning (used only on the accept edge)
   // ---------------------------------------------------------------------------
   logic [DW-1:0]     w_dvd_mag;
   logic [VW-1:0]     w_dvs_mag;
   logic              w_dvd_is_min;
   logic              w_dvs_is_m1;
   logic              w_dvs_is_zero;

   // Negating the most negative value wraps back to itself, which read as
   // unsigned is exactly its magnitude.
   assign w_dvd_mag     = dividend[DW-1] ? ({DW{1'b0}} - dividend) : dividend;
   assign w_dvs_mag     = divisor[VW-1]  ? ({VW{1'b0}} - divisor)  : divisor;
   assign w_dvd_is_min  = (dividend == {1'b1, {(DW-1){1'b0}}});
   assign w_dvs_is_m1   = &divisor;
   assign w_dvs_is_zero = ~|divisor;

   // ---------------------------------------------------------------------------
   // One restoring step
   // ---------------------------------------------------------------------------
   logic [VW+1:0]     w_sh;
   logic [VW+1:0]     w_sub;
   logic              w_ge;
   logic [VW:0]       w_rem_nxt;

   assign w_sh      = {r_rem, r_q[DW-1]};
   assign w_sub     = w_sh - {2'b00, r_dvs_mag};
   // The shifted remainder stays below 2^VW, so the top bit of the difference
   // is a reliable borrow flag.
   assign w_ge      = ~w_sub[VW+1];
   assign w_rem_nxt = w_ge ? w_sub[VW:0] : w_sh[VW:0];

   // ---------------------------------------------------------------------------
   // Sign fixup
   // ---------------------------------------------------------------------------
   logic [DW-1:0]     w_q_fix;
   logic [VW-1:0]     w_r_fix;

   // For the overflow case the magnitude 2^(DW-1) is left un-negated (both
   // signs negative) and so reads back as -2^(DW-1), the defined wrap value.
   assign w_q_fix = r_neg_q ? ({DW{1'b0}} - r_q) : r_q;
   assign w_r_fix = r_neg_r ? ({VW{1'b0}} - r_rem[VW-1:0]) : r_rem[VW-1:0];

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_q           <= '0;
         r_rem         <= '0;
         r_dvs_mag     <= '0;
         r_neg_q       <= 1'b0;
         r_neg_r       <= 1'b0;
         r_dvs_zero    <= 1'b0;
         r_ovf         <= 1'b0;
         r_dvd_lo      <= '0;
         r_din_ready   <= 1'b1;
         r_dout_valid  <= 1'b0;
         r_busy        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (din_valid) begin
                  r_state     <= StCalc;
                  r_din_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_q         <= w_dvd_mag;
                  r_rem       <= '0;
                  r_dvs_mag   <= w_dvs_mag;
                  r_neg_q     <= dividend[DW-1] ^ divisor[VW-1];
                  r_neg_r     <= dividend[DW-1];
                  r_dvs_zero  <= w_dvs_is_zero;
                  r_ovf       <= w_dvd_is_min & w_dvs_is_m1;
                  r_dvd_lo    <= dividend[VW-1:0];
                  r_cnt       <= CntW'(DW - 1);
               end
            end

            StCalc: begin
               r_rem <= w_rem_nxt;
               r_q   <= {r_q[DW-2:0], w_ge};
               if (r_cnt == '0) begin
                  r_state <= StFix;
               end else begin
                  r_cnt <= r_cnt - CntW'(1);
               end
            end

            StFix: begin
               r_state       <= StDone;
               r_dout_valid  <= 1'b1;
               r_div_by_zero <= r_dvs_zero;
               r_overflow    <= r_ovf;
               if (r_dvs_zero) begin
                  // The datapath result is meaningless for a zero divisor.
                  r_quotient  <= '0;
                  r_remainder <= r_dvd_lo;
               end else begin
                  r_quotient  <= w_q_fix;
                  r_remainder <= w_r_fix;
               end
            end

            StDone: begin
               // Result registers keep their values after the handshake.
               if (dout_ready) begin
                  r_state      <= StIdle;
                  r_dout_valid <= 1'b0;
                  r_din_ready  <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end

            default: begin
               r_state      <= StIdle;
               r_dout_valid <= 1'b0;
               r_din_ready  <= 1'b1;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign din_ready   = r_din_ready;
   assign dout_valid  = r_dout_valid;
   assign busy        = r_busy;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_lrhls_top_sdiv_seq_36s_18s.sv
// -----------------------------------------------------------------------------
// tb_lrhls_top_sdiv_seq_36s_18s
//
// Self-checking bench for the sequential signed divider. Directed scenarios
// use fixed expected values; the random run compares against a truncating
// signed division model built on 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_lrhls_top_sdiv_seq_36s_18s;

   localparam int DW = 36;
   localparam int VW = 18;
   localparam int LAT = 37;

   logic                 ap_clk = 1'b0;
   logic                 ap_rst_n = 1'b1;
   logic                 din_valid = 1'b0;
   logic                 din_ready;
   logic signed [DW-1:0] dividend = '0;
   logic signed [VW-1:0] divisor = '0;
   logic                 dout_valid;
   logic                 dout_ready = 1'b0;
   logic signed [DW-1:0] quotient;
   logic signed [VW-1:0] remainder;
   logic                 div_by_zero;
   logic                 overflow;
   logic                 busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 ap_clk = ~ap_clk;

   lrhls_top_sdiv_seq_36s_18s #(
      .DIVIDEND_WIDTH(DW),
      .DIVISOR_WIDTH (VW)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .overflow   (overflow),
      .busy       (busy)
   );

   // Reference: truncating signed division, remainder follows dividend sign.
   function automatic void ref_div(input logic signed [DW-1:0] a,
                                   input logic signed [VW-1:0] b,
                                   output logic signed [DW-1:0] q,
                                   output logic signed [VW-1:0] r,
                                   output logic dz, output logic ov);
      longint la, lb, lq, lr;
      la = a;
      lb = b;
      dz = (lb == 0);
      ov = (la == -64'sd34359738368) && (lb == -1);
      if (dz) begin
         q = '0;
         r = a[VW-1:0];
      end else begin
         lq = la / lb;
         lr = la % lb;
         q  = lq[DW-1:0];
         r  = lr[VW-1:0];
      end
   endfunction

   function automatic logic signed [DW-1:0] rand_dvd();
      logic [63:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 9))
         0:       return 36'sh8_0000_0000;
         1:       return 36'sh7_FFFF_FFFF;
         2:       return '0;
         3:       return 36'sd1;
         4:       return -36'sd1;
         5:       return {{20{w[15]}}, w[15:0]};
         default: return w[DW-1:0];
      endcase
   endfunction

   function automatic logic signed [VW-1:0] rand_dvs();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0:       return 18'sh20000;
         1:       return 18'sh1FFFF;
         2:       return '0;
         3:       return 18'sd1;
         4:       return -18'sd1;
         5:       return {{12{w[5]}}, w[5:0]};
         default: return w[VW-1:0];
      endcase
   endfunction

   // Drives one operand pair and waits (bounded) for dout_valid.
   // lat counts rising edges after the accept edge until dout_valid is seen.
   task automatic do_div(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b,
                         output int lat);
      int n;
      n = 0;
      while (din_ready !== 1'b1 && n < 200) begin
         @(posedge ap_clk); #1;
         n++;
      end
      dividend  = a;
      divisor   = b;
      din_valid = 1'b1;
      @(posedge ap_clk); #1;
      din_valid = 1'b0;
      n = 0;
      while (dout_valid !== 1'b1 && n < 100) begin
         @(posedge ap_clk); #1;
         n++;
      end
      lat = n;
   endtask

   task automatic retire();
      dout_ready = 1'b1;
      @(posedge ap_clk); #1;
      dout_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3 ap_rst_n = 1'b0;
      #20;
      n_checks++;
      if ({din_ready, dout_valid, busy, div_by_zero, overflow} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 10000",
                  {din_ready, dout_valid, busy, div_by_zero, overflow});
      end
      n_checks++;
      if (quotient !== '0 || remainder !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got q=%0d r=%0d want 0 0", quotient, remainder);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      n_checks++;
      if ({din_ready, dout_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want 100", {din_ready, dout_valid, busy});
      end
   endtask

   task automatic test_basic();
      int lat;
      do_div(36'sd100, 18'sd7, lat);
      n_checks++;
      if (lat != LAT) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
      end
      n_checks++;
      if (quotient !== 36'sd14 || remainder !== 18'sd2) begin
         n_fail++;
         $display("FAIL basic_result: got q=%0d r=%0d want 14 2", quotient, remainder);
      end
      n_checks++;
      if ({div_by_zero, overflow, din_ready, busy} !== 4'b0001) begin
         n_fail++;
         $display("FAIL basic_flags: got %b want 0001",
                  {div_by_zero, overflow, din_ready, busy});
      end
      retire();
      n_checks++;
      if ({dout_valid, din_ready, busy} !== 3'b010 || quotient !== 36'sd14) begin
         n_fail++;
         $display("FAIL basic_retire: got vrb=%b q=%0d want 010 14",
                  {dout_valid, din_ready, busy}, quotient);
      end
   endtask

   task automatic test_signs();
      logic signed [DW-1:0] ta [4];
      logic signed [VW-1:0] tb [4];
      logic signed [DW-1:0] eq [4];
      logic signed [VW-1:0] er [4];
      int lat;
      ta[0] = -36'sd100;       tb[0] = 18'sd7;       eq[0] = -36'sd14;     er[0] = -18'sd2;
      ta[1] = 36'sd100;        tb[1] = -18'sd7;      eq[1] = -36'sd14;     er[1] = 18'sd2;
      ta[2] = -36'sd100;       tb[2] = -18'sd7;      eq[2] = 36'sd14;      er[2] = -18'sd2;
      ta[3] = 36'sh7_FFFF_FFFF; tb[3] = 18'sh20000;  eq[3] = -36'sd262143; er[3] = 18'sd131071;
      for (int i = 0; i < 4; i++) begin
         do_div(ta[i], tb[i], lat);
         n_checks++;
         if (quotient !== eq[i] || remainder !== er[i] || lat != LAT) begin
            n_fail++;
            $display("FAIL signs_%0d: got q=%0d r=%0d lat=%0d want %0d %0d %0d",
                     i, quotient, remainder, lat, eq[i], er[i], LAT);
         end
         retire();
      end
   endtask

   task automatic test_special();
      int lat;
      do_div(36'sh8_0000_0000, -18'sd1, lat);
      n_checks++;
      if ({overflow, div_by_zero} !== 2'b10 || quotient !== 36'sh8_0000_0000 ||
          remainder !== '0) begin
         n_fail++;
         $display("FAIL overflow: got ov=%b dz=%b q=%h r=%0d want 1 0 800000000 0",
                  overflow, div_by_zero, quotient, remainder);
      end
      retire();
      do_div(36'sd12345, 18'sd0, lat);
      n_checks++;
      if ({overflow, div_by_zero} !== 2'b01 || quotient !== '0 ||
          remainder !== 18'sd12345 || lat != LAT) begin
         n_fail++;
         $display("FAIL div_by_zero: got ov=%b dz=%b q=%0d r=%0d lat=%0d want 0 1 0 12345 %0d",
                  overflow, div_by_zero, quotient, remainder, lat, LAT);
      end
      retire();
   endtask

   task automatic test_backpressure();
      logic signed [DW-1:0] eq, sq;
      logic signed [VW-1:0] er, sr;
      logic edz, eov;
      int lat;
      ref_div(-36'sd5000, 18'sd13, eq, er, edz, eov);
      do_div(-36'sd5000, 18'sd13, lat);
      n_checks++;
      if (quotient !== eq || remainder !== er || {div_by_zero, overflow} !== {edz, eov}) begin
         n_fail++;
         $display("FAIL bp_result: got q=%0d r=%0d want %0d %0d", quotient, remainder, eq, er);
      end
      sq = quotient;
      sr = remainder;
      for (int k = 0; k < 10; k++) begin
         dividend  = rand_dvd();
         divisor   = rand_dvs();
         din_valid = 1'b1;
         @(posedge ap_clk); #1;
         n_checks++;
         if ({dout_valid, din_ready, busy} !== 3'b101 || quotient !== sq || remainder !== sr) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got vrb=%b q=%0d r=%0d want 101 %0d %0d",
                     k, {dout_valid, din_ready, busy}, quotient, remainder, sq, sr);
         end
      end
      din_valid = 1'b0;
      retire();
      n_checks++;
      if ({dout_valid, din_ready} !== 2'b01 || quotient !== sq) begin
         n_fail++;
         $display("FAIL bp_release: got vr=%b q=%0d want 01 %0d",
                  {dout_valid, din_ready}, quotient, sq);
      end
      @(posedge ap_clk); #1;
      n_checks++;
      if ({dout_valid, din_ready, busy} !== 3'b010) begin
         n_fail++;
         $display("FAIL bp_idle: got %b want 010", {dout_valid, din_ready, busy});
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      dividend  = 36'sd1000;
      divisor   = 18'sd3;
      din_valid = 1'b1;
      @(posedge ap_clk); #1;
      din_valid = 1'b0;
      repeat (20) @(posedge ap_clk);
      #3;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_busy_before: got %b want 1", busy);
      end
      ap_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({din_ready, dout_valid, busy, div_by_zero, overflow} !== 5'b10000 ||
          quotient !== '0 || remainder !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got %b q=%0d r=%0d want 10000 0 0",
                  {din_ready, dout_valid, busy, div_by_zero, overflow}, quotient, remainder);
      end
      #3 ap_rst_n = 1'b1;
      do_div(36'sd1000, 18'sd10, lat);
      n_checks++;
      if (quotient !== 36'sd100 || remainder !== '0 || lat != LAT) begin
         n_fail++;
         $display("FAIL midrst_after: got q=%0d r=%0d lat=%0d want 100 0 %0d",
                  quotient, remainder, lat, LAT);
      end
      retire();
   endtask

   task automatic test_back_to_back();
      logic signed [DW-1:0] a, eq, sq;
      logic signed [VW-1:0] b, er, sr;
      logic edz, eov, sdz, sov;
      longint la, lb, lq, lr, ar, ab;
      int lat, stall;
      for (int i = 0; i < 600; i++) begin
         a = rand_dvd();
         b = rand_dvs();
         ref_div(a, b, eq, er, edz, eov);
         do_div(a, b, lat);
         n_checks++;
         if (quotient !== eq || remainder !== er || div_by_zero !== edz ||
             overflow !== eov || lat != LAT) begin
            n_fail++;
            $display("FAIL rand_%0d: a=%0d b=%0d got q=%0d r=%0d dz=%b ov=%b lat=%0d want %0d %0d %b %b %0d",
                     i, a, b, quotient, remainder, div_by_zero, overflow, lat,
                     eq, er, edz, eov, LAT);
         end
         if (b != 0) begin
            la = a; lb = b; lq = quotient; lr = remainder;
            ar = (lr < 0) ? -lr : lr;
            ab = (lb < 0) ? -lb : lb;
            n_checks++;
            if (!(ar < ab) || (!eov && (la != lq * lb + lr))) begin
               n_fail++;
               $display("FAIL rand_invariant_%0d: a=%0d b=%0d got q=%0d r=%0d",
                        i, a, b, quotient, remainder);
            end
         end
         sq = quotient; sr = remainder; sdz = div_by_zero; sov = overflow;
         stall = $urandom_range(0, 3);
         for (int k = 0; k < stall; k++) begin
            din_valid = $urandom_range(0, 1) == 1;
            dividend  = rand_dvd();
            divisor   = rand_dvs();
            @(posedge ap_clk); #1;
            n_checks++;
            if ({dout_valid, din_ready} !== 2'b10 || quotient !== sq || remainder !== sr ||
                {div_by_zero, overflow} !== {sdz, sov}) begin
               n_fail++;
               $display("FAIL rand_stall_%0d: got vr=%b q=%0d r=%0d want 10 %0d %0d",
                        i, {dout_valid, din_ready}, quotient, remainder, sq, sr);
            end
         end
         din_valid = 1'b0;
         retire();
         n_checks++;
         if ({dout_valid, din_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rand_retire_%0d: got %b want 01", i, {dout_valid, din_ready});
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_special();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
